// File: rtl/mips_mem_pkg.sv
// Shared types and helpers for the MEM-stage load/store initiator.
package mips_mem_pkg;

  localparam int unsigned ADDR_W = 18;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned CNT_W  = 4;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_READ  = 3'd1,
    ST_WRITE = 3'd2,
    ST_HOLD  = 3'd3,
    ST_RESP  = 3'd4
  } mau_state_t;

  // Request attributes that must survive past the accept edge.
  typedef struct packed {
    logic byte_op;
    logic sgn;
  } req_attr_t;

  function automatic logic [DATA_W-1:0] ext_byte(input logic [7:0] d, input logic sgn);
    return {{(DATA_W-8){sgn & d[7]}}, d};
  endfunction

endpackage

// File: rtl/mem_access_unit_if.sv
// Datapath request/response and memory_block strobe bundle.
interface mem_access_unit_if #(
  parameter int unsigned ADDR_W = 18
);
  import mips_mem_pkg::DATA_W;

  logic              req_valid;
  logic              req_ready;
  logic              req_store;
  logic              req_byte;
  logic              req_signed;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic              resp_valid;
  logic              resp_err;
  logic [DATA_W-1:0] resp_rdata;
  logic [ADDR_W-1:0] mem_address;
  logic [DATA_W-1:0] mem_write_data;
  logic [DATA_W-1:0] mem_read_data;
  logic              memRead;
  logic              memWrite;
  logic              byteOperations;

  // The access unit serves requests and drives the memory.
  modport slave (
    input  req_valid, req_store, req_byte, req_signed, req_addr, req_wdata, mem_read_data,
    output req_ready, resp_valid, resp_err, resp_rdata,
    output mem_address, mem_write_data, memRead, memWrite, byteOperations
  );

  modport master (
    output req_valid, req_store, req_byte, req_signed, req_addr, req_wdata, mem_read_data,
    input  req_ready, resp_valid, resp_err, resp_rdata,
    input  mem_address, mem_write_data, memRead, memWrite, byteOperations
  );

endinterface

// File: rtl/load_extend.sv
// Load-data extension; also used by the register-file writeback mux.
module load_extend import mips_mem_pkg::*; (
  input  logic [DATA_W-1:0] din,
  input  logic              byte_op,
  input  logic              sgn,
  output logic [DATA_W-1:0] dout_c
);

  always_comb begin
    dout_c = din;
    if (byte_op) dout_c = ext_byte(din[7:0], sgn);
  end

endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage load/store initiator: one request at a time, bounded access
// window toward memory_block, single-cycle response.
module mem_access_unit #(
  parameter int unsigned WAIT_CYCLES = 1,
  parameter int unsigned ADDR_W      = 18
) (
  input logic              clk,
  input logic              rst_n,
  mem_access_unit_if.slave bus
);
  import mips_mem_pkg::*;

  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(WAIT_CYCLES - 1);

  mau_state_t        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  req_attr_t         attr_q, attr_d;
  logic              err_q, err_d;
  logic              ready_q, ready_d;
  logic [DATA_W-1:0] ext_c;
  logic              accept_c, misalign_c, cnt_zero_c;

  // ready_q is only ever set while the FSM sits in IDLE.
  assign accept_c   = ready_q & bus.req_valid;
  assign misalign_c = ~bus.req_byte & (bus.req_addr[1:0] != 2'b00);
  assign cnt_zero_c = (cnt_q == '0);

  load_extend u_load_extend (
    .din    (bus.mem_read_data),
    .byte_op(attr_q.byte_op),
    .sgn    (attr_q.sgn),
    .dout_c (ext_c)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (accept_c) state_d = misalign_c ? ST_RESP : (bus.req_store ? ST_WRITE : ST_READ);
      ST_READ:  if (cnt_zero_c) state_d = ST_RESP;
      ST_WRITE: state_d = ST_HOLD;
      ST_HOLD:  if (cnt_zero_c) state_d = ST_RESP;
      ST_RESP:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Request capture, wait counter and load-data capture.
  always_comb begin
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    attr_d  = attr_q;
    err_d   = err_q;
    ready_d = (state_d == ST_IDLE);
    case (state_q)
      ST_IDLE: begin
        if (accept_c) begin
          addr_d         = bus.req_addr;
          wdata_d        = bus.req_wdata;
          attr_d.byte_op = bus.req_byte;
          attr_d.sgn     = bus.req_signed;
          err_d          = misalign_c;
          rdata_d        = '0;
          cnt_d          = CNT_LOAD;
        end
      end
      ST_READ: begin
        if (cnt_zero_c) rdata_d = ext_c;
        else            cnt_d   = cnt_q - CNT_W'(1);
      end
      ST_WRITE: cnt_d = CNT_LOAD;
      ST_HOLD:  if (!cnt_zero_c) cnt_d = cnt_q - CNT_W'(1);
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      attr_q  <= '0;
      err_q   <= 1'b0;
      ready_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      attr_q  <= attr_d;
      err_q   <= err_d;
      ready_q <= ready_d;
    end
  end

  // Outputs decode only registers and the state register.
  always_comb begin
    bus.req_ready      = ready_q;
    bus.memRead        = (state_q == ST_READ);
    bus.memWrite       = (state_q == ST_WRITE);
    bus.byteOperations = attr_q.byte_op & ((state_q == ST_READ) | (state_q == ST_WRITE));
    bus.mem_address    = addr_q;
    bus.mem_write_data = wdata_q;
    bus.resp_valid     = (state_q == ST_RESP);
    bus.resp_err       = (state_q == ST_RESP) & err_q;
    bus.resp_rdata     = (state_q == ST_RESP) ? rdata_q : '0;
  end

endmodule
